// File: rtl/avg_iq_capture_ctrl.sv
// Averaged-IQ snapshot sequencer: averages 2^LOG2_NAVG samples of one channel
// into each BRAM word and exposes a {busy, done, missed, count} status word.
module avg_iq_capture_ctrl #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LOG2_NAVG = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CH_W      = 8
) (
    input  logic                     user_clk,
    input  logic                     user_rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic                     sync_in,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          ch_idx,
    input  logic signed [DATA_W-1:0] i_in,
    input  logic signed [DATA_W-1:0] q_in,
    output logic                     bram_we,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [2*DATA_W-1:0]      bram_din,
    output logic [31:0]              addr_out
);

    localparam int unsigned ACC_W  = DATA_W + LOG2_NAVG;
    localparam int unsigned CNT_W  = LOG2_NAVG + 1;
    localparam int unsigned NAVG   = 1 << LOG2_NAVG;
    localparam int unsigned ZERO_W = 32 - 3 - (ADDR_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   state;
    logic [CH_W-1:0]          ch_q;
    logic signed [ACC_W-1:0]  acc_i;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         n_cnt;
    logic [ADDR_W:0]          wr_count;
    logic                     busy;
    logic                     done;
    logic                     missed;

    logic                     match_c;
    logic                     last_c;
    logic                     last_addr_c;
    logic signed [ACC_W-1:0]  sum_i_c;
    logic signed [ACC_W-1:0]  sum_q_c;

    // Running sums including the current sample, sign-extended to the accumulator width
    assign match_c     = in_valid && (ch_idx == ch_q);
    assign last_c      = (n_cnt == CNT_W'(NAVG - 1));
    assign last_addr_c = (wr_count[ADDR_W-1:0] == {ADDR_W{1'b1}});
    assign sum_i_c     = acc_i + {{LOG2_NAVG{i_in[DATA_W-1]}}, i_in};
    assign sum_q_c     = acc_q + {{LOG2_NAVG{q_in[DATA_W-1]}}, q_in};

    // Every status field is a flop, so the word is glitch-free for the PPC poll
    assign addr_out = {busy, done, missed, ZERO_W'(0), wr_count};

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state     <= S_IDLE;
            ch_q      <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            n_cnt     <= '0;
            wr_count  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            missed    <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_we <= 1'b0;
            if (abort) begin
                // Count and missed survive for readback; partial average is dropped
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                acc_i <= '0;
                acc_q <= '0;
                n_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            ch_q     <= ch_sel;
                            wr_count <= '0;
                            missed   <= 1'b0;
                            done     <= 1'b0;
                            acc_i    <= '0;
                            acc_q    <= '0;
                            n_cnt    <= '0;
                            busy     <= 1'b1;
                            state    <= S_WAIT_SYNC;
                        end
                    end
                    S_WAIT_SYNC: begin
                        if (sync_in) begin
                            state <= S_ACC;
                        end
                    end
                    S_ACC: begin
                        if (match_c) begin
                            acc_i <= sum_i_c;
                            acc_q <= sum_q_c;
                            n_cnt <= n_cnt + CNT_W'(1);
                            if (last_c) begin
                                // Upper DATA_W bits == sum >>> LOG2_NAVG (floor)
                                bram_we   <= 1'b1;
                                bram_addr <= wr_count[ADDR_W-1:0];
                                bram_din  <= {sum_i_c[ACC_W-1 -: DATA_W],
                                              sum_q_c[ACC_W-1 -: DATA_W]};
                                state     <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: begin
                        acc_i    <= '0;
                        acc_q    <= '0;
                        n_cnt    <= '0;
                        wr_count <= wr_count + (ADDR_W+1)'(1);
                        if (match_c) begin
                            missed <= 1'b1;
                        end
                        if (last_addr_c) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
